// File: rtl/tff_bank_sequencer.sv
// Drives a bank of external T flip-flops to a commanded pattern, either all differing
// bits at once (mode 0) or one bit per step LSB first (mode 1), with step-limit fault.
module tff_bank_sequencer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_STEPS = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic [1:0] {StIdle, StCheck, StApply, StDone} state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] low_bit;

  assign diff    = q ^ target_q;
  // Two's-complement trick isolates the lowest differing bit for the walk mode.
  assign low_bit = diff & (~diff + WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    t_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          mode_d   = cmd_mode;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (diff == '0) begin
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == MaxCnt) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          t_d     = mode_q ? low_bit : diff;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StApply;
        end
      end
      StApply: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StCheck;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      t_q      <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign t         = t_q;
  assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Self-checking bench: drives the sequencer against a modelled T flip-flop bank and
// compares each command's outcome with a per-command behavioural reference.
module tb_tff_bank_sequencer;

  localparam int unsigned W   = 4;
  localparam int unsigned MAX = 8;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_target;
  logic         cmd_mode;
  logic         abort;
  logic [W-1:0] q;
  logic [W-1:0] t;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   step_cnt;

  logic [W-1:0] stuck;
  logic [W-1:0] q_model;
  logic [W-1:0] exp_pulses[$];
  int           n_checks;
  int           n_pass;
  int           n_accept;

  tff_bank_sequencer #(
    .WIDTH    (W),
    .MAX_STEPS(MAX),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_mode  (cmd_mode),
    .abort     (abort),
    .q         (q),
    .t         (t),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .step_cnt  (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External flop bank; bits in 'stuck' are held at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= (q ^ t) & ~stuck;
  end

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) n_accept++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: replay the command rules step by step on a plain integer pattern.
  task automatic model_cmd(input logic [W-1:0] q0, input logic [W-1:0] tgt, input logic md,
                           input logic [W-1:0] stk, input int ab,
                           output logic [W-1:0] qf, output int steps, output logic e,
                           output int lat);
    logic [W-1:0] qq, d, m;
    bit fin;
    qq = q0; steps = 0; e = 1'b0; fin = 1'b0; lat = 0;
    exp_pulses.delete();
    for (int s = 0; s <= MAX + 1 && !fin; s++) begin
      d = qq ^ tgt;
      if (d == '0) begin
        fin = 1'b1; lat = 2 + 2 * steps;
      end else if (steps == MAX) begin
        fin = 1'b1; e = 1'b1; lat = 2 + 2 * steps;
      end else begin
        m = d;
        if (md) begin
          m = '0;
          for (int i = W - 1; i >= 0; i--) if (d[i]) m = W'(1) << i;
        end
        exp_pulses.push_back(m);
        qq = (qq ^ m) & ~stk;
        steps++;
        if (ab != 0 && steps == ab) begin
          fin = 1'b1; e = 1'b1; lat = 2 * steps + 1;
        end
      end
    end
    qf = qq;
  endtask

  task automatic run_cmd(input logic [W-1:0] tgt, input logic md, input int ab, input bit hold,
                         input string tag);
    logic [W-1:0] qf;
    logic [W-1:0] pulses[$];
    int steps, lat, obs_lat, acc0;
    logic e;
    bit ready_bad;
    model_cmd(q_model, tgt, md, stuck, ab, qf, steps, e, lat);
    cmd_valid = 1'b1; cmd_target = tgt; cmd_mode = md;
    check_eq($sformatf("%s/ready", tag), 32'(cmd_ready), 32'd1);
    acc0 = n_accept;
    @(negedge clk);
    obs_lat = 1; ready_bad = 1'b0;
    if (!hold) begin
      cmd_valid  = 1'b0;
      cmd_target = W'($urandom);
      cmd_mode   = 1'($urandom);
    end
    while (!done && obs_lat < 40) begin
      if (cmd_ready) ready_bad = 1'b1;
      if (t != '0) pulses.push_back(t);
      abort = (ab != 0 && t != '0 && pulses.size() == ab);
      @(negedge clk);
      obs_lat++;
    end
    abort = 1'b0; cmd_valid = 1'b0;
    check_eq($sformatf("%s/latency", tag), 32'(obs_lat), 32'(lat));
    check_eq($sformatf("%s/err", tag), 32'(err), 32'(e));
    check_eq($sformatf("%s/step_cnt", tag), 32'(step_cnt), 32'(steps));
    check_eq($sformatf("%s/t_at_done", tag), 32'(t), 32'd0);
    check_eq($sformatf("%s/q", tag), 32'(q), 32'(qf));
    check_eq($sformatf("%s/n_pulses", tag), 32'(pulses.size()), 32'(exp_pulses.size()));
    for (int i = 0; i < pulses.size() && i < exp_pulses.size(); i++)
      check_eq($sformatf("%s/pulse%0d", tag, i), 32'(pulses[i]), 32'(exp_pulses[i]));
    if (hold) begin
      check_eq($sformatf("%s/accepts", tag), 32'(n_accept - acc0), 32'd1);
      check_eq($sformatf("%s/ready_while_busy", tag), 32'(ready_bad), 32'd0);
    end
    @(negedge clk);
    check_eq($sformatf("%s/done_drop", tag), 32'(done), 32'd0);
    check_eq($sformatf("%s/idle_ready", tag), 32'(cmd_ready), 32'd1);
    check_eq($sformatf("%s/cnt_hold", tag), 32'(step_cnt), 32'(steps));
    q_model = qf;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q_model = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; n_accept = 0;
    cmd_valid = 1'b0; cmd_target = '0; cmd_mode = 1'b0; abort = 1'b0; stuck = '0;
    q_model = '0;
    rst_n = 1'b0;
    #1;
    check_eq("rst/t", 32'(t), 32'd0);
    check_eq("rst/ready", 32'(cmd_ready), 32'd1);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/done", 32'(done), 32'd0);
    check_eq("rst/step_cnt", 32'(step_cnt), 32'd0);
    do_reset();

    // Reset while t is being applied.
    cmd_valid = 1'b1; cmd_target = 4'b1111; cmd_mode = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && t == '0; i++) @(negedge clk);
    check_eq("midrst/apply_t", 32'(t), 32'b0001);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst/t", 32'(t), 32'd0);
    check_eq("midrst/ready", 32'(cmd_ready), 32'd1);
    check_eq("midrst/busy", 32'(busy), 32'd0);
    check_eq("midrst/done", 32'(done), 32'd0);
    check_eq("midrst/err", 32'(err), 32'd0);
    check_eq("midrst/step_cnt", 32'(step_cnt), 32'd0);
    check_eq("midrst/q", 32'(q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q_model = '0;
    @(negedge clk);

    run_cmd(4'b1011, 1'b0, 0, 1'b0, "par");
    run_cmd(4'b0110, 1'b1, 0, 1'b0, "walk");
    run_cmd(4'b0110, 1'b0, 0, 1'b0, "equal");
    run_cmd(4'b1001, 1'b1, 2, 1'b1, "abort_hold");

    stuck = 4'b0100;
    do_reset();
    run_cmd(4'b0100, 1'b1, 0, 1'b0, "stuck");
    stuck = '0;
    do_reset();

    for (int n = 0; n < 40; n++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_cmd(W'($urandom), 1'($urandom), ab, 1'($urandom_range(0, 1)),
              $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
